sd_ddr_writer: RTL and testbench

Downstream consumer of the SD card reader's 32-bit word stream. Buffers each `sd_valid`/`sd_data` word in an internal FIFO, packs it into fixed-length DDR write bursts at a linearly incrementing address, and flushes a zero-padded partial burst when the picture read completes. Sits between the SD top level and the DDR controller's user write port. It fills the frame buffer that the LCD path later reads.

---
 rtl/sd_ddr_writer.sv | 171 +++++++++++++++++
 tb/tb_sd_ddr_writer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_ddr_writer.sv
// sd_ddr_writer: buffers the SD reader's 32-bit word stream in a FIFO and
// writes it to DDR as fixed-length bursts at a linearly incrementing address.
// When the picture read completes, a partial burst is zero-padded and flushed,
// then frame_done pulses and the write address rewinds to the frame base.
module sd_ddr_writer #(
  parameter int          BURST_LEN  = 64,
  parameter int          FIFO_DEPTH = 256,
  parameter int          ADDR_W     = 24,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ddr_init_done,
  input  logic                        sd_valid,
  input  logic [31:0]                 sd_data,
  input  logic                        pic_read_done,
  output logic                        ddr_wr_req,
  output logic [ADDR_W-1:0]           ddr_wr_addr,
  input  logic                        ddr_wr_ack,
  input  logic                        ddr_wr_data_req,
  output logic [31:0]                 ddr_wr_data,
  output logic                        frame_done,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_BURST = LVL_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_BURST = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic [LVL_W-1:0]   level_d;
  logic               overflow_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               frame_done_q;
  logic               flush_pend_q;
  logic               pic_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [CNT_W-1:0]   pad_cnt_q;

  logic               full;
  logic               push;
  logic               pop;
  logic               pad_phase;

  // Beats past the real-word count of a flushed burst are zero padding.
  assign full      = (level_q == LVL_FULL);
  assign push      = sd_valid && !full;
  assign pad_phase = (beat_cnt_q >= (CNT_BURST - pad_cnt_q));
  assign pop       = (state_q == S_DATA) && ddr_wr_data_req && !pad_phase &&
                     (level_q != '0);

  // Occupancy next-state: a simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // FIFO control: pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      if (sd_valid && full) overflow_q <= 1'b1;
    end
  end

  // FIFO storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sd_data;
  end

  // Burst sequencer with flush tracking; all its outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT_INIT;
      req_q        <= 1'b0;
      addr_q       <= ADDR_BASE;
      frame_done_q <= 1'b0;
      flush_pend_q <= 1'b0;
      pic_q        <= 1'b0;
      beat_cnt_q   <= '0;
      pad_cnt_q    <= '0;
    end else begin
      pic_q        <= pic_read_done;
      frame_done_q <= 1'b0;
      if (pic_read_done && !pic_q) flush_pend_q <= 1'b1;
      case (state_q)
        S_WAIT_INIT: begin
          if (ddr_init_done) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (level_q >= LVL_BURST) begin
            pad_cnt_q <= '0;
            req_q     <= 1'b1;
            state_q   <= S_REQ;
          end else if (flush_pend_q && (level_q != '0)) begin
            // Latch the residual count; later pushes go to a later burst.
            pad_cnt_q <= CNT_BURST - level_q[CNT_W-1:0];
            req_q     <= 1'b1;
            state_q   <= S_REQ;
          end else if (flush_pend_q) begin
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_REQ: begin
          if (ddr_wr_ack) begin
            req_q      <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (ddr_wr_data_req) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (beat_cnt_q == CNT_LAST) begin
              addr_q  <= addr_q + ADDR_STEP;
              state_q <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          addr_q       <= ADDR_BASE;
          flush_pend_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_WAIT_INIT;
      endcase
    end
  end

  assign ddr_wr_req  = req_q;
  assign ddr_wr_addr = addr_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign fifo_level  = level_q;
  assign ddr_wr_data = ((level_q != '0) && !((state_q == S_DATA) && pad_phase)) ?
                       mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_sd_ddr_writer.sv
// Self-checking bench for sd_ddr_writer: a cycle-stepped DDR responder pops
// a scoreboard of expected words on every consumed beat; push/overflow levels
// come from a vector table, multi-cycle corners from hand-written sequences.
module tb_sd_ddr_writer;

  localparam int BL = 64;
  localparam int FD = 256;
  localparam int AW = 24;

  localparam int R_IDLE  = 0;
  localparam int R_WAIT  = 1;
  localparam int R_ACKED = 2;
  localparam int R_DATA  = 3;

  logic          clk;
  logic          rst;
  logic          ddr_init_done;
  logic          sd_valid;
  logic [31:0]   sd_data;
  logic          pic_read_done;
  logic          ddr_wr_req;
  logic [AW-1:0] ddr_wr_addr;
  logic          ddr_wr_ack;
  logic          ddr_wr_data_req;
  logic [31:0]   ddr_wr_data;
  logic          frame_done;
  logic          overflow;
  logic [8:0]    fifo_level;

  sd_ddr_writer #(
    .BURST_LEN (BL),
    .FIFO_DEPTH(FD),
    .ADDR_W    (AW),
    .BASE_ADDR (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ddr_init_done  (ddr_init_done),
    .sd_valid       (sd_valid),
    .sd_data        (sd_data),
    .pic_read_done  (pic_read_done),
    .ddr_wr_req     (ddr_wr_req),
    .ddr_wr_addr    (ddr_wr_addr),
    .ddr_wr_ack     (ddr_wr_ack),
    .ddr_wr_data_req(ddr_wr_data_req),
    .ddr_wr_data    (ddr_wr_data),
    .frame_done     (frame_done),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n_push;
    int exp_level;
    int exp_ovf;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] sb[$];
  int          burst_addrs[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc = 0;
  int          rs = R_IDLE;
  int          dly = 0;
  int          beats = 0;
  int          tog = 0;
  int          ack_delay = 3;
  int          gap = 0;
  int          rst_beat = -1;
  int          rst_fired = 0;
  int          push_left = 0;
  int          pic_on_last = 0;
  int          ovf_phase = 0;
  int          fd_count = 0;
  int          fd_cyc = 0;
  int          req_cyc = -1;
  int          last_push_cyc = 0;
  int          last_beat_cyc = 0;
  logic [31:0] next_word = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock of bench activity: sample, run the DDR responder, drive pushes.
  task automatic step();
    logic [31:0] exp_w;
    @(negedge clk);
    cyc++;
    if (frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
    ddr_wr_ack      = 1'b0;
    ddr_wr_data_req = 1'b0;
    if (!rst) begin
      case (rs)
        R_IDLE: if (ddr_wr_req) begin
          burst_addrs.push_back(int'(ddr_wr_addr));
          if (req_cyc < 0) req_cyc = cyc;
          if (ack_delay == 0) begin
            ddr_wr_ack = 1'b1;
            rs = R_ACKED;
          end else begin
            dly = ack_delay;
            rs = R_WAIT;
          end
        end
        R_WAIT: begin
          dly--;
          if (dly == 0) begin
            ddr_wr_ack = 1'b1;
            rs = R_ACKED;
          end
        end
        R_ACKED: begin
          chk("req_fall_after_ack", ddr_wr_req, 0);
          rs = R_DATA;
          beats = 0;
          tog = 0;
        end
        default: ;
      endcase
      if (rs == R_DATA) begin
        if (rst_beat >= 0 && beats == rst_beat) begin
          rst = 1'b1;
          rst_fired = 1;
          rs = R_IDLE;
        end else begin
          if (!(gap != 0 && tog != 0)) begin
            ddr_wr_data_req = 1'b1;
            exp_w = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            chk("beat_data", ddr_wr_data, exp_w);
            beats++;
            last_beat_cyc = cyc;
            if (beats == BL) rs = R_IDLE;
          end
          tog = 1 - tog;
        end
      end
    end
    sd_valid = 1'b0;
    if (push_left > 0) begin
      sd_valid = 1'b1;
      sd_data  = next_word;
      if (!(ovf_phase != 0 && sb.size() >= FD)) sb.push_back(next_word);
      next_word++;
      push_left--;
      last_push_cyc = cyc;
      if (push_left == 0 && pic_on_last != 0) pic_read_done = 1'b1;
    end
  endtask

  task automatic push_all(input int n);
    push_left = n;
    while (push_left > 0) step();
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (!(sb.size() == 0 && rs == R_IDLE && push_left == 0) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_in_time", (sb.size() == 0 && rs == R_IDLE) ? 1 : 0, 1);
    repeat (6) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pic_read_done = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    sb.delete();
    burst_addrs.delete();
    rs = R_IDLE;
    fd_count = 0;
    req_cyc = -1;
    rst_fired = 0;
    next_word = 0;
  endtask

  task automatic chk_bursts(input int n);
    chk("burst_count", burst_addrs.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < burst_addrs.size()) chk("burst_addr", burst_addrs[i], i * BL);
    end
  endtask

  initial begin
    vecs[0] = '{1, 1, 0};
    vecs[1] = '{9, 10, 0};
    vecs[2] = '{200, 210, 0};
    vecs[3] = '{46, 256, 0};
    vecs[4] = '{4, 256, 1};

    rst = 1'b1;
    ddr_init_done = 1'b0;
    sd_valid = 1'b0;
    sd_data = 32'h0;
    pic_read_done = 1'b0;
    ddr_wr_ack = 1'b0;
    ddr_wr_data_req = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_req", ddr_wr_req, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_addr", ddr_wr_addr, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_data", ddr_wr_data, 0);
    do_reset();

    // Overflow while DDR not calibrated, driven from the vector table
    ovf_phase = 1;
    for (int i = 0; i < 5; i++) begin
      push_all(vecs[i].n_push);
      step();
      chk("tbl_level", fifo_level, vecs[i].exp_level);
      chk("tbl_overflow", overflow, vecs[i].exp_ovf);
    end
    chk("wait_init_no_req", ddr_wr_req, 0);
    ovf_phase = 0;
    ddr_init_done = 1'b1;
    drain(2000);
    chk_bursts(4);
    chk("ovf_drain_addr", ddr_wr_addr, 256);
    chk("ovf_drain_level", fifo_level, 0);
    chk("overflow_sticky", overflow, 1);
    do_reset();
    step();
    chk("overflow_cleared", overflow, 0);

    // Single full burst, ack delay 3, continuous data requests
    ack_delay = 3;
    gap = 0;
    push_all(BL);
    drain(500);
    chk_bursts(1);
    chk("req_latency", req_cyc - last_push_cyc, 2);
    chk("single_addr", ddr_wr_addr, 64);
    chk("single_level", fifo_level, 0);

    // pic_read_done rising with the final push of a short frame
    do_reset();
    pic_on_last = 1;
    push_all(5);
    for (int i = 0; i < BL - 5; i++) sb.push_back(32'h0);
    drain(500);
    chk_bursts(1);
    chk("short_frame_done", fd_count, 1);
    chk("short_addr_rewind", ddr_wr_addr, 0);

    // Partial flush: 100 words then read done
    do_reset();
    push_all(100);
    for (int i = 0; i < 28; i++) sb.push_back(32'h0);
    drain(1000);
    chk_bursts(2);
    chk("partial_frame_done", fd_count, 1);
    chk("partial_addr_rewind", ddr_wr_addr, 0);
    pic_on_last = 0;

    // Gapped data requests with a push every cycle
    do_reset();
    ack_delay = 1;
    gap = 1;
    push_all(4 * BL);
    drain(3000);
    chk_bursts(4);
    chk("gap_overflow", overflow, 0);
    chk("gap_addr", ddr_wr_addr, 256);
    chk("gap_level", fifo_level, 0);
    gap = 0;

    // Reset at beat 20 of a burst
    do_reset();
    ack_delay = 2;
    rst_beat = 20;
    push_all(BL);
    begin
      int n;
      n = 0;
      while (rst_fired == 0 && n < 500) begin
        step();
        n++;
      end
    end
    chk("rst_mid_fired", rst_fired, 1);
    ddr_init_done = 1'b0;
    step();
    chk("rstmid_req", ddr_wr_req, 0);
    chk("rstmid_level", fifo_level, 0);
    chk("rstmid_addr", ddr_wr_addr, 0);
    chk("rstmid_data", ddr_wr_data, 0);
    rst = 1'b0;
    rst_beat = -1;
    rst_fired = 0;
    sb.delete();
    burst_addrs.delete();
    next_word = 0;
    push_all(BL);
    repeat (5) step();
    chk("rstmid_wait_init_no_req", ddr_wr_req, 0);
    chk("rstmid_refill_level", fifo_level, BL);
    ddr_init_done = 1'b1;
    drain(500);
    chk_bursts(1);

    // Empty flush: exactly two bursts, then read done
    do_reset();
    push_all(2 * BL);
    drain(1000);
    pic_read_done = 1'b1;
    repeat (12) step();
    chk_bursts(2);
    chk("empty_frame_done", fd_count, 1);
    chk("empty_fd_latency_ok", ((fd_cyc - last_beat_cyc) <= BL + 4) ? 1 : 0, 1);
    chk("empty_addr_rewind", ddr_wr_addr, 0);
    pic_read_done = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
